// File: rtl/irrigation_scheduler_if.sv
// Purpose: groups the scheduler's tick, request, level, acknowledge, valve and status signals.
// Latency: none, this is wiring only.
// Backpressure: none. Requests are level-held by the requester until the scheduler acts on them.
interface irrigation_scheduler_if;
    logic       tick;
    logic       asp_req;
    logic       got_req;
    logic       adb_req;
    logic [2:0] level;
    logic       clear;
    logic       valve_asp;
    logic       valve_got;
    logic       valve_in;
    logic       doser;
    logic       drain;
    logic       erro;
    logic [2:0] state;

    // Requester / environment side
    modport master (
        output tick, asp_req, got_req, adb_req, level, clear,
        input  valve_asp, valve_got, valve_in, doser, drain, erro, state
    );

    // Scheduler side
    modport slave (
        input  tick, asp_req, got_req, adb_req, level, clear,
        output valve_asp, valve_got, valve_in, doser, drain, erro, state
    );
endinterface

// File: rtl/irrigation_scheduler.sv
// Purpose: tank-fill, sprinkler/drip, fertilizer and cleaning scheduler FSM with a tick-based run timer.
// Latency: one clock from an input condition to the state change. Outputs decode the registered state.
// Backpressure: none. Requests are sampled in IDLE and ignored while in ERROR.
module irrigation_scheduler #(
    // Expected ranges: every parameter is 1..255, and LOW_LVL < FULL_LVL.
    parameter int LOW_LVL      = 2,
    parameter int FULL_LVL     = 7,
    parameter int MAX_RUN      = 15,
    parameter int FILL_TIMEOUT = 20,
    parameter int DOSE_TICKS   = 4,
    parameter int CLEAN_EVERY  = 4,
    parameter int CLEAN_TICKS  = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    irrigation_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ASP   = 3'd2,
        S_GOT   = 3'd3,
        S_DOSE  = 3'd4,
        S_CLEAN = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    localparam logic [7:0] LOW_L   = 8'(LOW_LVL);
    localparam logic [7:0] FULL_L  = 8'(FULL_LVL);
    localparam logic [7:0] RUN_L   = 8'(MAX_RUN);
    localparam logic [7:0] FILL_L  = 8'(FILL_TIMEOUT);
    localparam logic [7:0] DOSE_L  = 8'(DOSE_TICKS);
    localparam logic [7:0] EVERY_L = 8'(CLEAN_EVERY);
    localparam logic [7:0] CLEAN_L = 8'(CLEAN_TICKS);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [2:0] clean_cnt_q, clean_cnt_d;
    logic       last_got_q, last_got_d;    // 1 when the most recent IDLE grant went to drip
    logic       from_dose_q, from_dose_d;  // the current GOT run was entered from DOSE
    logic       cnt_up;

    logic lvl_low, lvl_full, lvl_empty, clean_due, clean_full;

    assign lvl_low    = {5'd0, bus.level} < LOW_L;
    assign lvl_full   = {5'd0, bus.level} >= FULL_L;
    assign lvl_empty  = bus.level == 3'd0;
    assign clean_due  = {5'd0, clean_cnt_q} == EVERY_L;
    assign clean_full = ({5'd0, clean_cnt_q} >= EVERY_L) || (clean_cnt_q == 3'd7);

    // True on the edge where the timer steps onto n, so a timed state lasts exactly n ticks.
    function automatic logic reached(input logic [7:0] n, input logic tk, input logic [7:0] t);
        return tk && (({1'b0, t} + 9'd1) == {1'b0, n});
    endfunction

    // Next-state, grant arbitration, cleaning counter and timer update.
    always_comb begin
        state_d     = state_q;
        clean_cnt_d = clean_cnt_q;
        last_got_d  = last_got_q;
        from_dose_d = from_dose_q;
        cnt_up      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (lvl_low) begin
                    state_d = S_FILL;
                end else if (clean_due) begin
                    state_d = S_CLEAN;
                end else if (bus.adb_req) begin
                    state_d = S_DOSE;
                end else if (bus.asp_req && (!bus.got_req || last_got_q)) begin
                    state_d    = S_ASP;
                    last_got_d = 1'b0;
                end else if (bus.got_req) begin
                    state_d     = S_GOT;
                    last_got_d  = 1'b1;
                    from_dose_d = 1'b0;
                end
            end
            S_FILL: begin
                if (lvl_full) begin
                    state_d = S_IDLE;
                end else if (reached(FILL_L, bus.tick, timer_q)) begin
                    state_d = S_ERROR;
                end
            end
            S_ASP: begin
                if (lvl_empty) begin
                    state_d = S_ERROR;
                end else if (!bus.asp_req || reached(RUN_L, bus.tick, timer_q)) begin
                    state_d = S_IDLE;
                    cnt_up  = 1'b1;
                end
            end
            S_GOT: begin
                if (lvl_empty) begin
                    state_d = S_ERROR;
                end else if ((!bus.got_req && !from_dose_q) || reached(RUN_L, bus.tick, timer_q)) begin
                    state_d = S_IDLE;
                    cnt_up  = 1'b1;
                end
            end
            S_DOSE: begin
                if (lvl_empty) begin
                    state_d = S_ERROR;
                end else if (reached(DOSE_L, bus.tick, timer_q)) begin
                    state_d     = S_GOT;
                    from_dose_d = 1'b1;
                end
            end
            S_CLEAN: begin
                if (reached(CLEAN_L, bus.tick, timer_q)) begin
                    state_d     = S_IDLE;
                    clean_cnt_d = 3'd0;
                end
            end
            S_ERROR: begin
                if (bus.clear) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (cnt_up && !clean_full) begin
            clean_cnt_d = clean_cnt_q + 3'd1;
        end

        if (state_d != state_q) begin
            timer_d = 8'd0;
        end else if (bus.tick && (timer_q != 8'hFF)) begin
            timer_d = timer_q + 8'd1;
        end else begin
            timer_d = timer_q;
        end
    end

    // State and bookkeeping registers. Reset is immediate and does not wait for a clock edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            timer_q     <= 8'd0;
            clean_cnt_q <= 3'd0;
            last_got_q  <= 1'b1;
            from_dose_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            clean_cnt_q <= clean_cnt_d;
            last_got_q  <= last_got_d;
            from_dose_q <= from_dose_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.valve_in  = state_q == S_FILL;
    assign bus.valve_asp = state_q == S_ASP;
    assign bus.valve_got = state_q == S_GOT;
    assign bus.doser     = state_q == S_DOSE;
    assign bus.drain     = state_q == S_CLEAN;
    assign bus.erro      = state_q == S_ERROR;

endmodule

// File: doc/irrigation_scheduler.md
IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

Interface
REQ-001 The block SHALL have parameter LOW_LVL, default 2, the tank level below which filling is mandatory.
REQ-002 The block SHALL have parameter FULL_LVL, default 7, the tank level that ends filling.
REQ-003 The block SHALL have parameter MAX_RUN, default 15, the maximum irrigation ticks per grant.
REQ-004 The block SHALL have parameter FILL_TIMEOUT, default 20, the maximum fill ticks before a fault.
REQ-005 The block SHALL have parameter DOSE_TICKS, default 4, the fertilizer dosing duration in ticks.
REQ-006 The block SHALL have parameter CLEAN_EVERY, default 4, the number of completed irrigations between cleanings.
REQ-007 The block SHALL have parameter CLEAN_TICKS, default 6, the drain duration in ticks.
REQ-008 The block SHALL have these ports, one per line:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- tick  input  1  one-cycle timing enable from the clock divider.
- asp_req  input  1  sprinkler irrigation request.
- got_req  input  1  drip irrigation request.
- adb_req  input  1  fertilizer request.
- level  input  3  tank level, binary 0-7.
- clear  input  1  error acknowledge.
- valve_asp  output  1  sprinkler valve.
- valve_got  output  1  drip valve.
- valve_in  output  1  tank inlet valve.
- doser  output  1  fertilizer pump.
- drain  output  1  cleaning drain valve.
- erro  output  1  fault indicator.
- state  output  3  current FSM state.

Function
REQ-009 The FSM SHALL use states IDLE=0, FILL=1, ASP=2, GOT=3, DOSE=4, CLEAN=5, ERROR=6; code 7 SHALL recover to IDLE on the next clock.
REQ-010 The outputs SHALL be Moore-decoded and registered-state only: valve_in in FILL, valve_asp in ASP, valve_got in GOT, doser in DOSE, drain in CLEAN, erro in ERROR; all others 0.
REQ-011 The 8-bit tick timer SHALL clear on every state entry, SHALL increment only on clock edges with tick=1, and the timed state SHALL last exactly N ticks (exit on the edge where the timer reaches N).
REQ-012 IDLE priority SHALL be: level<LOW_LVL -> FILL; else clean_cnt==CLEAN_EVERY -> CLEAN; else adb_req -> DOSE; else asp/got arbitration; else remain IDLE.
REQ-013 When both asp_req and got_req are 1 in IDLE, the grant SHALL go to the type opposite to last_grant; a single request SHALL be granted directly; last_grant SHALL update on every grant.
REQ-014 DOSE SHALL last DOSE_TICKS ticks and then go to GOT; sprinkler and doser SHALL never be active together.
REQ-015 ASP/GOT SHALL return to IDLE when its request is 0 at a clock edge or when the timer reaches MAX_RUN; an entry to GOT from DOSE SHALL ignore got_req=0 until the timer reaches MAX_RUN.
REQ-016 Each ASP/GOT exit to IDLE SHALL increment the 3-bit clean_cnt, saturating at CLEAN_EVERY.
REQ-017 In ASP, GOT, or DOSE, level==0 SHALL force ERROR on the next clock, taking precedence over every other exit.
REQ-018 FILL SHALL return to IDLE when level>=FULL_LVL; the timer reaching FILL_TIMEOUT SHALL force ERROR; if both occur on the same edge, IDLE SHALL win.
REQ-019 CLEAN SHALL last CLEAN_TICKS ticks, then go to IDLE with clean_cnt cleared.
REQ-020 ERROR SHALL hold until clear=1 at a clock edge, then go to IDLE; requests SHALL be ignored while in ERROR.
REQ-021 All parameters SHALL be between 1 and 255; LOW_LVL SHALL be less than FULL_LVL.

Reset
REQ-022 reset=0 SHALL immediately force state=IDLE, all outputs 0, timer=0, clean_cnt=0, and last_grant=GOT (the first contested grant goes to ASP), including during any active state.

Verification
REQ-023 level=1, no requests; raise level to 7 after 5 ticks -> FILL with valve_in=1 for 5 ticks, then IDLE.
REQ-024 level=5, asp_req=got_req=1 held -> ASP 15 ticks, IDLE, GOT 15 ticks, IDLE (alternating grants).
REQ-025 level=5, adb_req=1, got_req=0 -> doser=1 for 4 ticks, then valve_got=1 for 15 ticks; valve_asp stays 0 throughout.
REQ-026 level=5, got_req=1; drop level to 0 mid-GOT -> erro=1, all valves 0; clear=1 -> IDLE.
REQ-027 level=1 held for 20 ticks -> ERROR; separately, four short ASP grants -> CLEAN with drain=1 for 6 ticks, then clean_cnt=0.
REQ-028 Assert reset=0 mid-ASP, between clock edges -> valve_asp=0 and state=0 without waiting for a clock edge.
